if_fetch_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 16 +
 rtl/if_fetch_stage_if.sv | 30 +++
 rtl/if_fetch_stage_ifid.sv | 37 +++
 rtl/if_fetch_stage.sv | 95 +++++++++
 tb/tb_if_fetch_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction/PC constants and the fetch FSM state type.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port, IF/ID fields, perf counters.
interface if_fetch_stage_if;
    import mips_pkg::*;

    logic            stall;
    logic            if_flush;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ready;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] ifid_pc4;
    logic            ifid_valid;
    logic [XLEN-1:0] perf_stall_cnt;
    logic [XLEN-1:0] perf_flush_cnt;
    logic [XLEN-1:0] perf_wait_cnt;

    modport master (
        input  stall, if_flush, branch_target, imem_rdata, imem_ready,
        output imem_addr, ifid_instr, ifid_pc4, ifid_valid,
               perf_stall_cnt, perf_flush_cnt, perf_wait_cnt
    );

    modport slave (
        output stall, if_flush, branch_target, imem_rdata, imem_ready,
        input  imem_addr, ifid_instr, ifid_pc4, ifid_valid,
               perf_stall_cnt, perf_flush_cnt, perf_wait_cnt
    );

endinterface

// File: rtl/if_fetch_stage_ifid.sv
// IF/ID pipeline register; priority reset > hold > squash > load, otherwise holds.
module ifid_reg
    import mips_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            hold,
    input  logic            squash,
    input  logic            load,
    input  logic [XLEN-1:0] instr_d,
    input  logic [XLEN-1:0] pc4_d,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc4,
    output logic            valid
);

    always_ff @(posedge clock) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (hold) begin
            instr <= instr;
            pc4   <= pc4;
            valid <= valid;
        end else if (squash) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM and IF/ID register.
// Optional IF_PERF_CNT_EN enables saturating stall/flush/wait performance counters.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clock,
    input  logic                 reset,
    if_fetch_stage_if.master     bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            hold_c, squash_c, load_c;

    assign pc_plus4      = pc_q + PC_INC;
    assign bus.imem_addr = pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC & WORD_MASK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next PC / state and IF/ID controls; stall masks a flush because ID operands are stale.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_c   = 1'b0;
        squash_c = 1'b0;
        load_c   = 1'b0;
        if (bus.stall) begin
            hold_c = 1'b1;
        end else if (bus.if_flush) begin
            pc_d     = bus.branch_target & WORD_MASK;
            squash_c = 1'b1;
            state_d  = FETCH;
        end else if (!bus.imem_ready) begin
            squash_c = 1'b1;
            state_d  = WAIT;
        end else begin
            pc_d    = pc_plus4;
            load_c  = 1'b1;
            state_d = FETCH;
        end
    end

    ifid_reg u_ifid (
        .clock   (clock),
        .reset   (reset),
        .hold    (hold_c),
        .squash  (squash_c),
        .load    (load_c),
        .instr_d (bus.imem_rdata),
        .pc4_d   (pc_plus4),
        .instr   (bus.ifid_instr),
        .pc4     (bus.ifid_pc4),
        .valid   (bus.ifid_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic            flush_ev_c, wait_ev_c;
    logic [XLEN-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

    assign flush_ev_c = !bus.stall && bus.if_flush;
    assign wait_ev_c  = !bus.stall && !bus.if_flush && !bus.imem_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (bus.stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + XLEN'(1);
            if (flush_ev_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + XLEN'(1);
            if (wait_ev_c && (wait_cnt_q != '1))  wait_cnt_q  <= wait_cnt_q + XLEN'(1);
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
    assign bus.perf_wait_cnt  = wait_cnt_q;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
    assign bus.perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage (default PC and wrap-around reset PC instances).
module tb_if_fetch_stage;

    logic clock;
    logic reset;
    logic reset2;
    int   n_checks;
    int   n_fail;

    if_fetch_stage_if bus  ();
    if_fetch_stage_if bus2 ();

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clock (clock),
        .reset (reset2),
        .bus   (bus2.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Advance one cycle and settle past the edge before checking.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.stall        = 1'b0;
        bus.if_flush     = 1'b0;
        bus.imem_ready   = 1'b1;
        bus.imem_rdata   = 32'h0;
        bus.branch_target = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] rdata);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = rdata;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_addr",  bus.imem_addr,  32'h0);
        chk("reset_instr", bus.ifid_instr, 32'h0);
        chk("reset_pc4",   bus.ifid_pc4,   32'h0);
        chk("reset_valid", 32'(bus.ifid_valid), 32'h0);
        chk("reset_cnt",   bus.perf_stall_cnt | bus.perf_flush_cnt | bus.perf_wait_cnt, 32'h0);
    endtask

    task automatic test_fetch();
        logic [31:0] instrs [3];
        instrs[0] = 32'hAAAA_0001;
        instrs[1] = 32'hBBBB_0002;
        instrs[2] = 32'hCCCC_0003;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("fetch_addr_pre", bus.imem_addr, 32'(4 * i));
            fetch(instrs[i]);
            chk("fetch_instr", bus.ifid_instr, instrs[i]);
            chk("fetch_pc4",   bus.ifid_pc4,   32'(4 * (i + 1)));
            chk("fetch_valid", 32'(bus.ifid_valid), 32'h1);
        end
        chk("fetch_addr_end", bus.imem_addr, 32'hC);
    endtask

    task automatic test_stall_flush();
        do_reset();
        fetch(32'hAAAA_0001);
        fetch(32'hBBBB_0002);
        bus.stall = 1'b1;
        bus.imem_rdata = 32'hCCCC_0003;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_addr",  bus.imem_addr,  32'h8);
            chk("stall_instr", bus.ifid_instr, 32'hBBBB_0002);
            chk("stall_pc4",   bus.ifid_pc4,   32'h8);
            chk("stall_valid", 32'(bus.ifid_valid), 32'h1);
        end
        bus.stall = 1'b0;
        fetch(32'hCCCC_0003);
        chk("resume_addr",  bus.imem_addr,  32'hC);
        chk("resume_instr", bus.ifid_instr, 32'hCCCC_0003);
        chk("resume_pc4",   bus.ifid_pc4,   32'hC);
        // Taken branch redirects to word-aligned target with a single bubble.
        bus.if_flush = 1'b1;
        bus.branch_target = 32'h0000_0103;
        bus.imem_rdata = 32'hDEAD_DEAD;
        tick();
        bus.if_flush = 1'b0;
        chk("flush_addr",  bus.imem_addr,  32'h100);
        chk("flush_instr", bus.ifid_instr, 32'h0);
        chk("flush_valid", 32'(bus.ifid_valid), 32'h0);
        chk("flush_cnt",   bus.perf_flush_cnt, PERF ? 32'h1 : 32'h0);
        fetch(32'hEEEE_0100);
        chk("target_addr",  bus.imem_addr,  32'h104);
        chk("target_instr", bus.ifid_instr, 32'hEEEE_0100);
        chk("target_pc4",   bus.ifid_pc4,   32'h104);
        chk("target_valid", 32'(bus.ifid_valid), 32'h1);
        // Flush during stall is ignored.
        bus.stall = 1'b1;
        bus.if_flush = 1'b1;
        bus.branch_target = 32'h0000_0200;
        tick();
        bus.stall = 1'b0;
        bus.if_flush = 1'b0;
        chk("sf_addr",      bus.imem_addr,  32'h104);
        chk("sf_instr",     bus.ifid_instr, 32'hEEEE_0100);
        chk("sf_valid",     32'(bus.ifid_valid), 32'h1);
        chk("sf_flush_cnt", bus.perf_flush_cnt, PERF ? 32'h1 : 32'h0);
        chk("sf_stall_cnt", bus.perf_stall_cnt, PERF ? 32'h3 : 32'h0);
    endtask

    task automatic test_wait();
        do_reset();
        for (int i = 0; i < 4; i++) fetch(32'h1000_0000 + 32'(i));
        chk("wait_pre_addr", bus.imem_addr, 32'h10);
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr",  bus.imem_addr,  32'h10);
            chk("wait_instr", bus.ifid_instr, 32'h0);
            chk("wait_valid", 32'(bus.ifid_valid), 32'h0);
        end
        chk("wait_cnt", bus.perf_wait_cnt, PERF ? 32'h3 : 32'h0);
        fetch(32'hF00D_0010);
        chk("wait_resume_addr",  bus.imem_addr,  32'h14);
        chk("wait_resume_instr", bus.ifid_instr, 32'hF00D_0010);
        chk("wait_resume_pc4",   bus.ifid_pc4,   32'h14);
        // Reset in the middle of a memory wait.
        bus.imem_ready = 1'b0;
        tick();
        chk("midwait_valid", 32'(bus.ifid_valid), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midwait_rst_addr",  bus.imem_addr, 32'h0);
        chk("midwait_rst_valid", 32'(bus.ifid_valid), 32'h0);
        chk("midwait_rst_cnt",   bus.perf_wait_cnt, 32'h0);
        fetch(32'h1234_5678);
        chk("postrst_addr",  bus.imem_addr,  32'h4);
        chk("postrst_instr", bus.ifid_instr, 32'h1234_5678);
        chk("postrst_valid", 32'(bus.ifid_valid), 32'h1);
    endtask

    task automatic test_wrap();
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0;
        chk("wrap_reset_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        bus2.imem_ready = 1'b1;
        bus2.imem_rdata = 32'hCAFE_F00D;
        tick();
        chk("wrap_addr",  bus2.imem_addr,  32'h0);
        chk("wrap_pc4",   bus2.ifid_pc4,   32'h0);
        chk("wrap_instr", bus2.ifid_instr, 32'hCAFE_F00D);
        chk("wrap_valid", 32'(bus2.ifid_valid), 32'h1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        reset2   = 1'b1;
        bus2.stall         = 1'b0;
        bus2.if_flush      = 1'b0;
        bus2.branch_target = 32'h0;
        bus2.imem_ready    = 1'b0;
        bus2.imem_rdata    = 32'h0;
        test_reset();
        test_fetch();
        test_stall_flush();
        test_wait();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
